memory_stage: RTL

MEMORY_STAGE -- requirements
Module: memory_stage

---
 rtl/mips_pkg.sv | 35 +++
 rtl/data_memory.sv | 33 +++
 rtl/memory_stage.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: datapath widths, the memory-stage FSM
// state encoding and the EX/MEM pipeline register layout.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    // Memory-stage sequencing: loads spend one extra cycle waiting for the
    // registered RAM read; everything else completes straight from IDLE.
    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } mem_state_e;

    // Everything the execute stage hands over, plus its valid bit.
    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] result;
        logic              zero;
        logic [DATA_W-1:0] addResult;
        logic [DATA_W-1:0] storeData;
        logic [REG_W-1:0]  destReg;
        logic              branch;
        logic              memRead;
        logic              memWrite;
        logic              memToReg;
        logic              regWrite;
    } exmem_t;

    // Word accesses need the two byte-offset bits of the address clear.
    function automatic logic word_aligned(input logic [1:0] byte_off);
        return (byte_off == 2'b00);
    endfunction

endpackage

// File: rtl/data_memory.sv
// Single-port synchronous data RAM. A read returns the word as it was
// before any write in the same cycle (no write-first bypass); read data is
// registered and appears the cycle after the read enable.
module data_memory
    import mips_pkg::*;
#(
    parameter int WORDS = 256,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [WORDS];
    logic [DATA_W-1:0] rdata_q;

    // Storage and read register; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/memory_stage.sv
// MIPS memory stage: EX/MEM pipeline register, branch resolution, a data
// RAM access with one stall cycle per load, and the MEM/WB output register.
// Misaligned word accesses are dropped and reported with a one-cycle pulse.
module memory_stage
    import mips_pkg::*;
#(
    parameter int MEM_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] result,
    input  logic              zero,
    input  logic [DATA_W-1:0] addResult,
    input  logic [DATA_W-1:0] storeData,
    input  logic [REG_W-1:0]  destReg,
    input  logic              branch,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic              memToReg,
    input  logic              regWrite,
    output logic              stall,
    output logic              pcSrc,
    output logic [DATA_W-1:0] branchTarget,
    output logic              wbValid,
    output logic              wbRegWrite,
    output logic [REG_W-1:0]  wbReg,
    output logic [DATA_W-1:0] wbData,
    output logic              misaligned
);

    localparam int AW = $clog2(MEM_WORDS);

    exmem_t            exm_q, exm_d;
    mem_state_e        state_q;

    logic              aligned;
    logic              mis_op;
    logic              load_go;
    logic              store_go;
    logic              complete;
    logic [AW-1:0]     mem_addr;
    logic [DATA_W-1:0] mem_rdata;

    logic              wbValid_q,    wbValid_d;
    logic              wbRegWrite_q, wbRegWrite_d;
    logic [REG_W-1:0]  wbReg_q,      wbReg_d;
    logic [DATA_W-1:0] wbData_q,     wbData_d;
    logic              mis_q,        mis_d;

    // Decode of the operation currently sitting in EX/MEM. Address bits
    // above the word index are ignored, so addresses wrap over the RAM.
    assign aligned  = word_aligned(exm_q.result[1:0]);
    assign mis_op   = exm_q.valid & (exm_q.memRead | exm_q.memWrite) & ~aligned;
    assign load_go  = exm_q.valid & exm_q.memRead  & aligned & (state_q == IDLE);
    assign store_go = exm_q.valid & exm_q.memWrite & aligned & (state_q == IDLE);
    assign mem_addr = exm_q.result[AW+1:2];

    // A load finishes at the end of LOAD_WAIT; anything else (including a
    // dropped misaligned load) finishes after its single EX/MEM cycle.
    assign complete = exm_q.valid &
                      ((state_q == LOAD_WAIT) | ~(exm_q.memRead & aligned));

    // Only the issuing cycle of an aligned load holds the upstream stage.
    assign stall        = load_go;
    assign pcSrc        = exm_q.valid & exm_q.branch & exm_q.zero;
    assign branchTarget = exm_q.addResult;

    // EX/MEM capture: take the execute outputs unless this cycle stalls.
    always_comb begin
        exm_d = exm_q;
        if (!stall) begin
            exm_d.valid     = ex_valid;
            exm_d.result    = result;
            exm_d.zero      = zero;
            exm_d.addResult = addResult;
            exm_d.storeData = storeData;
            exm_d.destReg   = destReg;
            exm_d.branch    = branch;
            exm_d.memRead   = memRead;
            exm_d.memWrite  = memWrite;
            exm_d.memToReg  = memToReg;
            exm_d.regWrite  = regWrite;
        end
    end

    // EX/MEM register; reset drops any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exm_q <= '0;
        end else begin
            exm_q <= exm_d;
        end
    end

    // Load sequencer: one wait cycle after issuing the RAM read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE:      if (load_go) state_q <= LOAD_WAIT;
                LOAD_WAIT: state_q <= IDLE;
                default:   state_q <= IDLE;
            endcase
        end
    end

    data_memory #(
        .WORDS (MEM_WORDS)
    ) u_dmem (
        .clk     (clk),
        .we_i    (store_go),
        .re_i    (load_go),
        .addr_i  (mem_addr),
        .wdata_i (exm_q.storeData),
        .rdata_o (mem_rdata)
    );

    // MEM/WB next state: payload updates only when an operation completes.
    always_comb begin
        wbValid_d    = complete;
        wbRegWrite_d = complete & exm_q.regWrite & ~mis_op;
        mis_d        = complete & mis_op;
        wbReg_d      = wbReg_q;
        wbData_d     = wbData_q;
        if (complete) begin
            wbReg_d  = exm_q.destReg;
            wbData_d = exm_q.memToReg ? mem_rdata : exm_q.result;
        end
    end

    // MEM/WB register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbValid_q    <= 1'b0;
            wbRegWrite_q <= 1'b0;
            wbReg_q      <= '0;
            wbData_q     <= '0;
            mis_q        <= 1'b0;
        end else begin
            wbValid_q    <= wbValid_d;
            wbRegWrite_q <= wbRegWrite_d;
            wbReg_q      <= wbReg_d;
            wbData_q     <= wbData_d;
            mis_q        <= mis_d;
        end
    end

    assign wbValid    = wbValid_q;
    assign wbRegWrite = wbRegWrite_q;
    assign wbReg      = wbReg_q;
    assign wbData     = wbData_q;
    assign misaligned = mis_q;

endmodule
